// File: rtl/masked_sbox_pkg.sv
// GF(2^8) arithmetic, AES affine matrices, randomness slicing and pipeline
// stage records shared by the masked S-box datapath.
package masked_sbox_pkg;

  localparam logic [7:0] AINV_CONST = 8'h05;
  localparam logic [7:0] AFF_CONST  = 8'h63;
  localparam logic [8:0] GF_POLY    = 9'h11B;

  // PRNG slices: [3:0] delta level 1, [6:4] delta levels 2-3, r, b
  localparam int RND_DELTA_L1 = 0;
  localparam int RND_DELTA_L2 = 4;
  localparam int RND_R_LSB    = 7;
  localparam int RND_B_LSB    = 15;

  // Linear parts of the affine maps; output bit i = parity(x & ROWS[i])
  localparam logic [7:0] AINV_ROWS [0:7] = '{8'hA4, 8'h49, 8'h92, 8'h25, 8'h4A, 8'h94, 8'h29, 8'h52};
  localparam logic [7:0] AFF_ROWS  [0:7] = '{8'hF1, 8'hE3, 8'hC7, 8'h8F, 8'h1F, 8'h3E, 8'h7C, 8'hF8};

  function automatic logic [7:0] ainv_lin(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = ^(x & AINV_ROWS[i]);
    return y;
  endfunction

  function automatic logic [7:0] a_lin(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = ^(x & AFF_ROWS[i]);
    return y;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ GF_POLY[7:0]) : {sh[6:0], 1'b0};
    end
    return acc;
  endfunction

  // x^254; maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Domain-oriented AND of shared bits x=(x0,x1), y=(y0,y1); returns {z1, z0}
  function automatic logic [1:0] dom_and(input logic x0, input logic x1,
                                         input logic y0, input logic y1,
                                         input logic r);
    return {(x1 & y1) ^ ((x1 & y0) ^ r), (x0 & y0) ^ ((x0 & y1) ^ r)};
  endfunction

  typedef struct packed {
    logic       vld;
    logic       inv;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [3:0] z0;
    logic [3:0] z1;
    logic [2:0] rd;
    logic [7:0] r;
    logic [7:0] b;
  } st1_t;

  typedef struct packed {
    logic       vld;
    logic       inv;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [1:0] z0;
    logic [1:0] z1;
    logic       rd;
    logic [7:0] r;
    logic [7:0] b;
  } st2_t;

  typedef struct packed {
    logic       vld;
    logic       inv;
    logic [7:0] a0;
    logic [7:0] a1;
    logic       d0;
    logic       d1;
    logic [7:0] r;
    logic [7:0] b;
  } st3_t;

  typedef struct packed {
    logic       vld;
    logic       inv;
    logic [7:0] p0;
    logic [7:0] p1;
    logic       d0;
    logic       d1;
    logic [7:0] r;
    logic [7:0] b;
  } st4_t;

  typedef struct packed {
    logic       vld;
    logic       inv;
    logic [7:0] cb;
    logic [7:0] rb;
    logic       d0;
    logic       d1;
    logic [7:0] r;
  } st5_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] s0;
    logic [7:0] s1;
  } st6_t;

endpackage

// File: rtl/gf256_mul.sv
// Combinational 8x8 multiplier in GF(2^8) over the AES polynomial.
module gf256_mul
  import masked_sbox_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  assign p = gf_mul(a, b);

endmodule

// File: rtl/masked_inv_sbox.sv
// Two-share multiplicatively masked AES inverse S-box, 6-stage pipeline.
// Define MASKED_SBOX_BIDIR_EN to add the `inv` port and a forward S-box mode.
module masked_inv_sbox
  import masked_sbox_pkg::*;
#(
  parameter int RAND_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RAND_W-1:0] PRNG,
  input  logic              in_valid,
  input  logic [15:0]       inp,
`ifdef MASKED_SBOX_BIDIR_EN
  input  logic              inv,
`endif
  output logic              out_valid,
  output logic [15:0]       SB_out
);

  st1_t st1_d, st1_q;
  st2_t st2_d, st2_q;
  st3_t st3_d, st3_q;
  st4_t st4_d, st4_q;
  st5_t st5_d, st5_q;
  st6_t st6_d, st6_q;

  logic       inv_in;
  logic [7:0] a0_in, a1_in, na0, na1;
  logic [7:0] y0, y1, r_eff;
  logic [7:0] p0_mul, p1_mul, rb_mul, rcb_mul;
  logic [7:0] o0, o1;

`ifdef MASKED_SBOX_BIDIR_EN
  assign inv_in = inv;
`else
  assign inv_in = 1'b1;
`endif

  // Share-wise affine: constant only on share 0; forward mode passes x through
  assign a0_in = inv_in ? (ainv_lin(inp[15:8]) ^ AINV_CONST) : inp[15:8];
  assign a1_in = inv_in ? ainv_lin(inp[7:0]) : inp[7:0];
  assign na0   = ~a0_in;
  assign na1   = a1_in;

  // a==0 is folded into bit 0 so the multiplicative mask never meets zero
  assign y0    = st3_q.a0 ^ {7'b0, st3_q.d0};
  assign y1    = st3_q.a1 ^ {7'b0, st3_q.d1};
  assign r_eff = (st3_q.r == 8'h00) ? 8'h01 : st3_q.r;

  gf256_mul u_mul_y0  (.a(y0),       .b(r_eff),     .p(p0_mul));
  gf256_mul u_mul_y1  (.a(y1),       .b(r_eff),     .p(p1_mul));
  gf256_mul u_mul_rb  (.a(st4_q.r),  .b(st4_q.b),   .p(rb_mul));
  gf256_mul u_mul_rcb (.a(st5_q.r),  .b(st5_q.cb),  .p(rcb_mul));

  assign o0 = st5_q.rb ^ {7'b0, st5_q.d0};
  assign o1 = rcb_mul  ^ {7'b0, st5_q.d1};

  always_comb begin
    // NOTE: each stage record is defaulted before any field is written, so no
    // path through this block can leave a bit unassigned and infer a latch.
    st1_d     = '0;
    st1_d.vld = in_valid;
    st1_d.inv = inv_in;
    st1_d.a0  = a0_in;
    st1_d.a1  = a1_in;
    for (int k = 0; k < 4; k++)
      {st1_d.z1[k], st1_d.z0[k]} = dom_and(na0[2*k], na1[2*k], na0[2*k+1], na1[2*k+1],
                                           PRNG[RND_DELTA_L1 + k]);
    st1_d.rd  = PRNG[RND_DELTA_L2 +: 3];
    st1_d.r   = PRNG[RND_R_LSB +: 8];
    st1_d.b   = PRNG[RND_B_LSB +: 8];

    st2_d     = '0;
    st2_d.vld = st1_q.vld;
    st2_d.inv = st1_q.inv;
    st2_d.a0  = st1_q.a0;
    st2_d.a1  = st1_q.a1;
    for (int k = 0; k < 2; k++)
      {st2_d.z1[k], st2_d.z0[k]} = dom_and(st1_q.z0[2*k], st1_q.z1[2*k],
                                           st1_q.z0[2*k+1], st1_q.z1[2*k+1], st1_q.rd[k]);
    st2_d.rd  = st1_q.rd[2];
    st2_d.r   = st1_q.r;
    st2_d.b   = st1_q.b;

    // Final AND of all complemented bits: d0^d1 = (a == 0)
    st3_d     = '0;
    st3_d.vld = st2_q.vld;
    st3_d.inv = st2_q.inv;
    st3_d.a0  = st2_q.a0;
    st3_d.a1  = st2_q.a1;
    {st3_d.d1, st3_d.d0} = dom_and(st2_q.z0[0], st2_q.z1[0], st2_q.z0[1], st2_q.z1[1], st2_q.rd);
    st3_d.r   = st2_q.r;
    st3_d.b   = st2_q.b;

    st4_d     = '0;
    st4_d.vld = st3_q.vld;
    st4_d.inv = st3_q.inv;
    st4_d.p0  = p0_mul;
    st4_d.p1  = p1_mul;
    st4_d.d0  = st3_q.d0;
    st4_d.d1  = st3_q.d1;
    st4_d.r   = r_eff;
    st4_d.b   = st3_q.b;

    // y*r is safe to unmask: the product is uniformly masked by r
    st5_d     = '0;
    st5_d.vld = st4_q.vld;
    st5_d.inv = st4_q.inv;
    st5_d.cb  = gf_inv(st4_q.p0 ^ st4_q.p1) ^ st4_q.b;
    st5_d.rb  = rb_mul;
    st5_d.d0  = st4_q.d0;
    st5_d.d1  = st4_q.d1;
    st5_d.r   = st4_q.r;

    st6_d     = '0;
    st6_d.vld = st5_q.vld;
    st6_d.s0  = st5_q.inv ? o0 : (a_lin(o0) ^ AFF_CONST);
    st6_d.s1  = st5_q.inv ? o1 : a_lin(o1);
  end

  // NOTE: every pipeline register is cleared on reset, so in-flight beats and
  // their masks are discarded and the outputs read zero at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st1_q <= '0;
      st2_q <= '0;
      st3_q <= '0;
      st4_q <= '0;
      st5_q <= '0;
      st6_q <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's old value.
      st1_q <= st1_d;
      st2_q <= st2_d;
      st3_q <= st3_d;
      st4_q <= st4_d;
      st5_q <= st5_d;
      st6_q <= st6_d;
    end
  end

  assign out_valid = st6_q.vld;
  assign SB_out    = {st6_q.s0, st6_q.s1};

endmodule

// File: tb/tb_masked_inv_sbox.sv
// Directed bench for masked_inv_sbox: golden-table vectors, a 256-value stream,
// mid-flight reset and, with MASKED_SBOX_BIDIR_EN, forward/inverse interleaving.
module tb_masked_inv_sbox;

  localparam int RW = 23;

  logic          clk;
  logic          rst;
  logic [RW-1:0] PRNG;
  logic          in_valid;
  logic [15:0]   inp;
  logic          out_valid;
  logic [15:0]   SB_out;
`ifdef MASKED_SBOX_BIDIR_EN
  logic          inv;
`endif

  int n_cmp        = 0;
  int n_fail       = 0;
  int n_valid_seen = 0;

  // Expected {valid, unshared value} for each beat still inside the 6-deep pipe
  logic       ev_v [0:5];
  logic [7:0] ev_d [0:5];

  localparam logic [7:0] INV_TAB [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef struct packed {
    logic [7:0]    x;
    logic [7:0]    mask;
    logic [RW-1:0] rnd;
    logic [7:0]    exp;
  } vec_t;

  vec_t vecs [0:9];

  masked_inv_sbox #(.RAND_W(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .PRNG     (PRNG),
    .in_valid (in_valid),
    .inp      (inp),
`ifdef MASKED_SBOX_BIDIR_EN
    .inv      (inv),
`endif
    .out_valid(out_valid),
    .SB_out   (SB_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_sb();
    for (int i = 0; i < 6; i++) begin
      ev_v[i] = 1'b0;
      ev_d[i] = 8'h00;
    end
  endtask

  // One clock: drive a beat at the falling edge, then compare whatever the
  // scoreboard says should be leaving the pipe six rising edges after entry.
  task automatic cycle(input logic v, input logic [7:0] x, input logic [7:0] m,
                       input logic [RW-1:0] rnd, input logic inv_b, input logic [7:0] exp);
    in_valid = v;
    inp      = {x ^ m, m};
    PRNG     = rnd;
`ifdef MASKED_SBOX_BIDIR_EN
    inv      = inv_b;
`endif
    @(posedge clk);
    for (int i = 5; i > 0; i--) begin
      ev_v[i] = ev_v[i-1];
      ev_d[i] = ev_d[i-1];
    end
    ev_v[0] = v;
    ev_d[0] = exp;
    @(negedge clk);
    check("out_valid", {15'b0, out_valid}, {15'b0, ev_v[5]});
    if (ev_v[5]) check("unshared", {8'h00, SB_out[15:8] ^ SB_out[7:0]}, {8'h00, ev_d[5]});
    if (out_valid) n_valid_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, '0, 1'b1, 8'h00);
  endtask

  initial begin
    logic [RW-1:0] rnd;
    logic [7:0]    m;

    vecs[0] = '{8'hAA, 8'h00, 23'h5A3C71, 8'h62};
    vecs[1] = '{8'h63, 8'h50, 23'h12F0E3, 8'h00};
    vecs[2] = '{8'h00, 8'h00, 23'h3C55AA, 8'h52};
    vecs[3] = '{8'h7C, 8'h00, 23'h0F0F0F, 8'h01};
    vecs[4] = '{8'hED, 8'hC4, 23'h6B2D19, 8'h53};
    vecs[5] = '{8'hFF, 8'h81, 23'h7F807F, 8'h7D};
    vecs[6] = '{8'h01, 8'hFE, 23'h000000, 8'h09};
    vecs[7] = '{8'h63, 8'hFF, 23'h7FFFFF, 8'h00};
    vecs[8] = '{8'h52, 8'h13, 23'h2468AC, 8'h48};
    vecs[9] = '{8'h10, 8'h77, 23'h13579B, 8'h7C};

    rst      = 1'b0;
    in_valid = 1'b0;
    inp      = '0;
    PRNG     = '0;
`ifdef MASKED_SBOX_BIDIR_EN
    inv      = 1'b1;
`endif
    clear_sb();

    #1 rst = 1'b1;
    #2;
    check("reset out_valid", {15'b0, out_valid}, 16'h0000);
    check("reset SB_out", SB_out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors back to back, including both a==0 inputs and r==0
    for (int i = 0; i < 10; i++)
      cycle(1'b1, vecs[i].x, vecs[i].mask, vecs[i].rnd, 1'b1, vecs[i].exp);
    idle(6);

    // All 256 inputs back to back, fresh share mask per beat, r slice forced 0
    n_valid_seen = 0;
    for (int i = 0; i < 256; i++) begin
      rnd        = RW'($urandom);
      rnd[14:7]  = 8'h00;
      m          = 8'($urandom);
      cycle(1'b1, 8'(i), m, rnd, 1'b1, INV_TAB[i]);
    end
    idle(6);
    check("stream valid count", 16'(n_valid_seen), 16'd256);

    // Reset with beats in flight and one already at the output
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 8'(8'h20 + i), 8'(8'h5A + 3 * i), RW'($urandom), 1'b1, INV_TAB[8'h20 + i]);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid-reset out_valid", {15'b0, out_valid}, 16'h0000);
    check("mid-reset SB_out", SB_out, 16'h0000);
    clear_sb();
    @(posedge clk);
    @(negedge clk);
    check("held-reset out_valid", {15'b0, out_valid}, 16'h0000);
    rst = 1'b0;
    n_valid_seen = 0;
    cycle(1'b1, 8'hC7, 8'h3B, 23'h4D2C1B, 1'b1, INV_TAB[8'hC7]);
    idle(8);
    check("post-reset valid count", 16'(n_valid_seen), 16'd1);

`ifdef MASKED_SBOX_BIDIR_EN
    cycle(1'b1, 8'h53, 8'h9C, 23'h31A5C7, 1'b0, 8'hED);
    cycle(1'b1, 8'hED, 8'h21, 23'h5E0F12, 1'b1, 8'h53);
    cycle(1'b1, 8'h00, 8'h6E, 23'h0ABCDE, 1'b0, 8'h63);
    cycle(1'b1, 8'h63, 8'h18, 23'h7F807F, 1'b1, 8'h00);
    cycle(1'b1, 8'h01, 8'hA5, 23'h2B4C6D, 1'b0, 8'h7C);
    cycle(1'b1, 8'h7C, 8'h42, 23'h13579B, 1'b1, 8'h01);
    cycle(1'b1, 8'hFF, 8'hD3, 23'h000000, 1'b0, 8'h16);
    cycle(1'b1, 8'h16, 8'h0F, 23'h6A6A6A, 1'b1, 8'hFF);
    idle(6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
